period_meter: RTL

- Receiver counterpart to the blinker square-wave generator.
- Samples an asynchronous square-wave input and measures each cycle in main-clock ticks:
  - full period, rising edge to rising edge;
  - high time.
- Publishes each result with a one-cycle valid strobe.
- Flags loss of signal with a timeout.
- Used on the keyboard path to check tone and LED-blink generators, and to measure external pulse sources.

---
 rtl/period_meter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// period_meter: measures the full period and high time of an asynchronous
// square wave in clk cycles, with a valid strobe per period, a lock flag and
// a loss-of-signal timeout.
module period_meter #(
  parameter int unsigned C_CLK_FRQ    = 100_000_000,
  parameter int unsigned C_CNT_W      = 32,
  parameter int unsigned C_TIMEOUT_MS = 100
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               in,
  output logic [C_CNT_W-1:0] period,
  output logic [C_CNT_W-1:0] high_time,
  output logic               valid,
  output logic               locked,
  output logic               timeout
);

  // Longest period accepted before the input is declared lost.
  localparam longint unsigned C_TIMEOUT =
    longint'(C_CLK_FRQ) / 1000 * longint'(C_TIMEOUT_MS);

  // The counters must be able to hold the timeout value itself.
  generate
    if (C_TIMEOUT >= (64'd1 << C_CNT_W)) begin : gTimeoutTooWide
      $error("period_meter: C_TIMEOUT does not fit in C_CNT_W bits");
    end
  endgenerate

  localparam logic [C_CNT_W-1:0] TIMEOUT_CNT = C_CNT_W'(C_TIMEOUT);
  localparam logic [C_CNT_W-1:0] ONE_CNT     = C_CNT_W'(1);

  // ARM: one rise seen, first period being counted (nothing to publish yet).
  // MEASURE: at least one period published, locked.
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} stateType;

  stateType            stateReg, stateNext;
  logic [2:0]          syncReg;          // [0]=s1, [1]=s2, [2]=s3 history
  logic [C_CNT_W-1:0]  cntPReg, cntPNext;
  logic [C_CNT_W-1:0]  cntHReg, cntHNext;
  logic [C_CNT_W-1:0]  periodNext, highTimeNext;
  logic                validNext, lockedNext, timeoutNext;
  logic                inHigh;
  logic                rise;

  assign inHigh = syncReg[1];
  assign rise   = syncReg[1] & ~syncReg[2];

  // Two-flop synchronizer followed by one history flop for edge detection.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) syncReg <= 3'b000;
    else       syncReg <= {syncReg[1:0], in};
  end

  // Next-state, counter and result logic; a rise always beats the timeout.
  always_comb begin
    stateNext    = stateReg;
    cntPNext     = cntPReg;
    cntHNext     = cntHReg;
    periodNext   = period;
    highTimeNext = high_time;
    validNext    = 1'b0;
    timeoutNext  = 1'b0;
    lockedNext   = locked;
    case (stateReg)
      IDLE: begin
        if (rise) begin
          stateNext = ARM;
          cntPNext  = ONE_CNT;
          cntHNext  = {{(C_CNT_W-1){1'b0}}, inHigh};
        end
      end
      ARM, MEASURE: begin
        if (rise) begin
          stateNext    = MEASURE;
          periodNext   = cntPReg;
          highTimeNext = cntHReg;
          validNext    = 1'b1;
          lockedNext   = 1'b1;
          cntPNext     = ONE_CNT;
          cntHNext     = {{(C_CNT_W-1){1'b0}}, inHigh};
        end else if (cntPReg == TIMEOUT_CNT) begin
          stateNext    = IDLE;
          periodNext   = '0;
          highTimeNext = '0;
          timeoutNext  = 1'b1;
          lockedNext   = 1'b0;
          cntPNext     = '0;
          cntHNext     = '0;
        end else begin
          cntPNext = cntPReg + ONE_CNT;
          if (inHigh) cntHNext = cntHReg + ONE_CNT;
        end
      end
      default: begin
        stateNext = IDLE;
        cntPNext  = '0;
        cntHNext  = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // Counters and registered outputs; results change together with valid.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cntPReg   <= '0;
      cntHReg   <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cntPReg   <= cntPNext;
      cntHReg   <= cntHNext;
      period    <= periodNext;
      high_time <= highTimeNext;
      valid     <= validNext;
      locked    <= lockedNext;
      timeout   <= timeoutNext;
    end
  end

endmodule
